// File: rtl/tdc_multihit_core.sv
// Multi-hit time-interval core: converts start/stop thermometer snapshots plus a
// coarse cycle count into tap-unit intervals, buffered in a FWFT output FIFO.
module tdc_multihit_core #(
  parameter int NUM_TAPS   = 64,
  parameter int COARSE_W   = 8,
  parameter int DIG_OUT    = 16,
  parameter int MAX_HITS   = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int FINE_W    = $clog2(NUM_TAPS + 1),
  localparam int HIT_W     = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NUM_TAPS-1:0] iStartTaps,
  input  logic                iStartValid,
  input  logic [NUM_TAPS-1:0] iStopTaps,
  input  logic                iStopValid,
  output logic [DIG_OUT-1:0]  oTDC,
  output logic [HIT_W-1:0]    oHitIdx,
  output logic                oOverflow,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBusy,
  output logic                done,
  output logic                oDropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DIG_OUT + HIT_W + 1;

  function automatic logic [FINE_W-1:0] popcount(input logic [NUM_TAPS-1:0] taps);
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_TAPS; i++) n = n + FINE_W'(taps[i]);
    return n;
  endfunction

  function automatic logic [DIG_OUT-1:0] interval(input logic [COARSE_W-1:0] c,
                                                  input logic [FINE_W-1:0]   f_start,
                                                  input logic [FINE_W-1:0]   f_stop);
    return DIG_OUT'(c) * DIG_OUT'(NUM_TAPS) + DIG_OUT'(f_start) - DIG_OUT'(f_stop);
  endfunction

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t              state;
  logic [COARSE_W-1:0] cnt;
  logic [HIT_W-1:0]    hit;
  logic [FINE_W-1:0]   fs;
  logic                busy_r, done_r;
  logic                stop_acc, tmo, last_stop;

  assign stop_acc  = (state == ARMED) && iStopValid;
  assign tmo       = (state == ARMED) && !iStopValid && (cnt == '1);
  assign last_stop = stop_acc && ((hit == HIT_W'(MAX_HITS - 1)) || (cnt == '1));

  // cnt is loaded with 1 because it already ticks in the start cycle, so its
  // value in any armed cycle equals the number of cycles since the start.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      cnt    <= '0;
      hit    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (iStartValid) begin
            state  <= ARMED;
            cnt    <= COARSE_W'(1);
            hit    <= '0;
            busy_r <= 1'b1;
          end
        end
        ARMED: begin
          cnt <= cnt + 1'b1;
          if (stop_acc) hit <= hit + 1'b1;
          if (last_stop || tmo) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (state == IDLE && iStartValid) fs <= popcount(iStartTaps);
  end

  // Stage p0: stop fine code and its coarse/hit tags
  logic                vld_p0;
  logic [COARSE_W-1:0] c_p0;
  logic [FINE_W-1:0]   fp_p0;
  logic [HIT_W-1:0]    hit_p0;

  always_ff @(posedge iClk) begin
    if (iRst) vld_p0 <= 1'b0;
    else      vld_p0 <= stop_acc;
  end

  always_ff @(posedge iClk) begin
    if (stop_acc) begin
      c_p0   <= cnt;
      fp_p0  <= popcount(iStopTaps);
      hit_p0 <= hit;
    end
  end

  // Stage p1: interval or timeout word; a timeout colliding with a stop result waits one cycle
  logic               vld_p1, ovf_p1, tmo_pend;
  logic [DIG_OUT-1:0] res_p1;
  logic [HIT_W-1:0]   hit_p1, tmo_hit;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_p1   <= 1'b0;
      tmo_pend <= 1'b0;
    end else begin
      vld_p1   <= vld_p0 || tmo || tmo_pend;
      tmo_pend <= (tmo || tmo_pend) && vld_p0;
    end
  end

  always_ff @(posedge iClk) begin
    if (tmo) tmo_hit <= hit;
    if (vld_p0) begin
      res_p1 <= interval(c_p0, fs, fp_p0);
      hit_p1 <= hit_p0;
      ovf_p1 <= 1'b0;
    end else if (tmo || tmo_pend) begin
      res_p1 <= '1;
      hit_p1 <= tmo ? hit : tmo_hit;
      ovf_p1 <= 1'b1;
    end
  end

  // Output FIFO, first-word-fall-through
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, wr_ok, dropped_r;
  logic [EW-1:0] head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && iReady;
  assign wr_ok = vld_p1 && (!full || pop);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_r <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(pop);
      if (vld_p1 && !wr_ok) dropped_r <= 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_ok) mem[wr_ptr] <= {ovf_p1, hit_p1, res_p1};
  end

  assign head      = mem[rd_ptr];
  assign oValid    = !empty;
  assign oTDC      = empty ? '0 : head[DIG_OUT-1:0];
  assign oHitIdx   = empty ? '0 : head[DIG_OUT +: HIT_W];
  assign oOverflow = !empty && head[EW-1];
  assign oBusy     = busy_r;
  assign done      = done_r;
  assign oDropped  = dropped_r;

endmodule

// File: tb/tb_tdc_multihit_core.sv
// Bench for tdc_multihit_core: directed timing steps plus randomized measurements
// checked against an ordered queue of intervals computed from start/stop rules.
module tb_tdc_multihit_core;

  localparam int NT = 64;
  localparam int MH = 4;
  localparam int FD = 8;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [NT-1:0] iStartTaps, iStopTaps;
  logic          iStartValid, iStopValid, iReady;
  logic [15:0]   oTDC;
  logic [1:0]    oHitIdx;
  logic          oOverflow, oValid, oBusy, done, oDropped;

  tdc_multihit_core #(
    .NUM_TAPS(NT), .COARSE_W(8), .DIG_OUT(16), .MAX_HITS(MH), .FIFO_DEPTH(FD)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iStartTaps(iStartTaps), .iStartValid(iStartValid),
    .iStopTaps(iStopTaps), .iStopValid(iStopValid),
    .oTDC(oTDC), .oHitIdx(oHitIdx), .oOverflow(oOverflow), .oValid(oValid),
    .iReady(iReady), .oBusy(oBusy), .done(done), .oDropped(oDropped)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [15:0] tdc;
    logic [1:0]  hit;
    logic        ovf;
  } word_t;

  word_t       expq[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          bp_mode = 1'b0;
  bit          exp_drop = 1'b0;
  bit          rnd_ready = 1'b0;
  int          g_offs[4];
  logic [63:0] g_stp[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [63:0] thermo(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (n >= 64) ? '1 : ((one << n) - one);
  endfunction

  function automatic logic [63:0] bubble(input int n);
    logic [63:0] t;
    t = thermo(n);
    for (int i = 0; i < 3; i++) begin
      int   p;
      logic b;
      p = $urandom_range(62, 0);
      b = t[p];
      t[p] = t[p+1];
      t[p+1] = b;
    end
    return t;
  endfunction

  task automatic push_exp(input int t, input int h, input logic o);
    word_t w;
    w.tdc = 16'(t);
    w.hit = 2'(h);
    w.ovf = o;
    if (!bp_mode || expq.size() < FD) expq.push_back(w);
    else exp_drop = 1'b1;
  endtask

  task automatic observe();
    word_t w;
    if (rnd_ready) iReady = 1'($urandom_range(1, 0));
    if (oValid && iReady) begin
      if (expq.size() == 0) chk("extra_word", oValid, 0);
      else begin
        w = expq.pop_front();
        chk("tdc", oTDC, w.tdc);
        chk("hitidx", oHitIdx, w.hit);
        chk("overflow", oOverflow, w.ovf);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tdc"}, oTDC, 0);
    chk({tag, "_hit"}, oHitIdx, 0);
    chk({tag, "_ovf"}, oOverflow, 0);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dropped"}, oDropped, 0);
  endtask

  // One measurement: start now, stops at g_offs[0..nst-1] cycles after start.
  task automatic run_meas(input logic [63:0] st, input int nst, input bit same_stop);
    int fs, h, si, k;
    bit ended;
    fs = $countones(st);
    iStartValid = 1'b1;
    iStartTaps = st;
    if (same_stop) begin
      iStopValid = 1'b1;
      iStopTaps = bubble(7);
    end
    observe();
    tick();
    iStartValid = 1'b0;
    iStopValid = 1'b0;
    h = 0; si = 0; k = 1; ended = 1'b0;
    while (!ended) begin
      chk("busy_armed", oBusy, 1);
      chk("done_armed", done, 0);
      if (si < nst && g_offs[si] == k) begin
        iStopValid = 1'b1;
        iStopTaps = g_stp[si];
        push_exp(k * NT + fs - $countones(g_stp[si]), h, 1'b0);
        h++; si++;
        ended = (h == MH) || (k == 255);
      end else if (k == 255) begin
        push_exp(16'hFFFF, h, 1'b1);
        ended = 1'b1;
      end
      observe();
      tick();
      iStopValid = 1'b0;
      k++;
    end
    chk("done_pulse", done, 1);
    chk("busy_fall", oBusy, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    iReady = 1'b1;
    while (expq.size() > 0 && n < 100) begin
      observe();
      tick();
      n++;
    end
    chk("drain_left", expq.size(), 0);
    chk("empty_after_drain", oValid, 0);
  endtask

  initial begin
    iRst = 1'b1; iStartValid = 1'b0; iStopValid = 1'b0; iReady = 1'b1;
    iStartTaps = '0; iStopTaps = '0;
    tick(); tick();
    check_reset_vals("reset");
    iRst = 1'b0;
    tick();

    // Single hit, exact latency, then timeout of the same measurement
    iStartValid = 1'b1; iStartTaps = thermo(20);
    tick(); iStartValid = 1'b0;
    chk("single_busy", oBusy, 1);
    tick(); tick();
    iStopValid = 1'b1; iStopTaps = thermo(50);
    tick(); iStopValid = 1'b0;
    chk("single_n1_valid", oValid, 0);
    tick();
    chk("single_n2_valid", oValid, 0);
    tick();
    chk("single_n3_valid", oValid, 1);
    chk("single_tdc", oTDC, 162);
    chk("single_hit", oHitIdx, 0);
    chk("single_ovf", oOverflow, 0);
    chk("single_still_busy", oBusy, 1);
    tick();
    chk("single_popped", oValid, 0);
    repeat (248) tick();
    chk("tmo_cycle_busy", oBusy, 1);
    chk("tmo_cycle_done", done, 0);
    tick();
    chk("tmo_done", done, 1);
    chk("tmo_busy_fall", oBusy, 0);
    chk("tmo_not_yet_valid", oValid, 0);
    tick();
    chk("tmo_valid", oValid, 1);
    chk("tmo_tdc", oTDC, 16'hFFFF);
    chk("tmo_ovf", oOverflow, 1);
    chk("tmo_hit", oHitIdx, 1);
    tick();
    chk("tmo_popped", oValid, 0);

    // Multi-hit
    g_offs = '{1, 2, 5, 9};
    g_stp[0] = thermo(64); g_stp[1] = bubble(32); g_stp[2] = '0; g_stp[3] = bubble(10);
    run_meas(64'd0, 4, 1'b0);
    drain();

    // Timeout with no stops, immediately followed by a bubbled-stop measurement
    run_meas(bubble(33), 0, 1'b0);
    g_offs[0] = 1; g_stp[0] = 64'h000000000000FFF7;
    run_meas(thermo(15), 1, 1'b0);
    drain();

    // Stop coincident with C=255, then start+stop in the same IDLE cycle
    g_offs[0] = 3; g_offs[1] = 255; g_stp[0] = bubble(5); g_stp[1] = bubble(60);
    run_meas(bubble(40), 2, 1'b0);
    g_offs[0] = 2; g_stp[0] = bubble(12);
    run_meas(bubble(22), 1, 1'b1);
    drain();

    // Backpressure: three 4-hit measurements into an 8-entry FIFO
    bp_mode = 1'b1; exp_drop = 1'b0; iReady = 1'b0;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) begin
        g_offs[i] = 2 * i + 1 + m;
        g_stp[i] = bubble($urandom_range(64, 0));
      end
      run_meas(bubble($urandom_range(64, 0)), 4, 1'b0);
    end
    repeat (4) begin observe(); tick(); end
    chk("bp_dropped", oDropped, exp_drop);
    chk("bp_held", oValid, 1);
    chk("bp_model_held", expq.size(), FD);
    bp_mode = 1'b0;
    drain();
    chk("bp_dropped_sticky", oDropped, 1);

    // Reset mid-measurement with two results in flight
    iStartValid = 1'b1; iStartTaps = bubble(30);
    tick(); iStartValid = 1'b0;
    iStopValid = 1'b1; iStopTaps = bubble(10);
    tick(); iStopTaps = bubble(40);
    tick(); iStopValid = 1'b0;
    iRst = 1'b1;
    tick(); iRst = 1'b0;
    check_reset_vals("midrst");
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_valid", oValid, 0);
      tick();
    end
    g_offs[0] = 4; g_stp[0] = bubble(9);
    run_meas(bubble(50), 1, 1'b0);
    drain();

    // Randomized measurements with random consumer stalls
    for (int r = 0; r < 6; r++) begin
      int nst, k;
      nst = $urandom_range(4, 0);
      k = 0;
      for (int i = 0; i < 4; i++) begin
        k += $urandom_range(40, 1);
        g_offs[i] = k;
        g_stp[i] = bubble($urandom_range(64, 0));
      end
      rnd_ready = 1'b1;
      run_meas(bubble($urandom_range(64, 0)), nst, 1'b0);
      rnd_ready = 1'b0;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
